// File: rtl/ysyx_25060170_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_pkg
// Definitions shared by the ysyx_25060170 NPC pipeline stages (IFU, IDU, ...).
//   ifu_state_e      - fetch-unit FSM states
//   fault_cause_e    - sticky fault cause codes reported by the IFU
//   RESP_OK          - memory read response code meaning "no error"
//   RESET_PC_DEFAULT - address of the first instruction after reset
//   pc_aligned()     - true when a PC is a legal 32-bit instruction address
// ----------------------------------------------------------------------------
package ysyx_25060170_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } ifu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_BUS      = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } fault_cause_e;

  localparam logic [1:0]  RESP_OK          = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Instructions are word-sized and word-aligned; the low two bits must be 0.
  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_ifu
// Instruction fetch unit of the multi-cycle NPC. Holds the architectural PC,
// reads one instruction over a valid/ready read channel, hands {pc, inst} to
// the IDU, then waits for the next PC from execute/writeback.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_arvalid_o/araddr_o     read-address request (address = current PC)
//   mem_arready_i              memory accepts the address
//   mem_rvalid_i/rdata_i/rresp_i  read data channel; rresp != OK is a bus error
//   mem_rready_o               IFU accepts read data
//   inst_valid_o/inst_ready_i  handshake toward the IDU
//   pc_o, inst_o               presented PC and instruction word
//   upd_valid_i, upd_pc_i      next-PC update from execute/writeback
//   fault_o, fault_cause_o     sticky fault flag and its cause; IFU halts
//   fetch_cnt_o                instructions handed to the IDU (wraps)
// ----------------------------------------------------------------------------
module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  output logic        mem_rready_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fetch_cnt_o
);

  ifu_state_e   state;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic [31:0]  fetch_cnt;
  logic         fault;
  fault_cause_e cause;

  // Single FSM: every register (including pc/inst) is reset so that a reset
  // mid-transaction leaves nothing of the aborted fetch behind. A response
  // arriving while reset is held is dropped because state is forced to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      fetch_cnt <= 32'h0;
      fault     <= 1'b0;
      cause     <= CAUSE_NONE;
    end else begin
      case (state)
        // One-cycle gap after reset release before the first request.
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (mem_arready_i) state <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_rresp_i == RESP_OK) begin
              inst  <= mem_rdata_i;
              state <= S_OUT;
            end else begin
              // Keep the previous instruction word; only the fault is recorded.
              fault <= 1'b1;
              cause <= CAUSE_BUS;
              state <= S_FAULT;
            end
          end
        end

        S_OUT: begin
          if (inst_ready_i) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (upd_valid_i) begin
            // The PC is taken even when misaligned so the bad target is
            // visible on pc_o for debugging.
            pc <= upd_pc_i;
            if (pc_aligned(upd_pc_i)) begin
              state <= S_REQ;
            end else begin
              fault <= 1'b1;
              cause <= CAUSE_MISALIGN;
              state <= S_FAULT;
            end
          end
        end

        S_FAULT: state <= S_FAULT;

        default: state <= S_FAULT;
      endcase
    end
  end

  // Handshake outputs depend on the state register only, never on inputs.
  assign mem_arvalid_o = (state == S_REQ);
  assign mem_rready_o  = (state == S_WAIT);
  assign inst_valid_o  = (state == S_OUT);

  assign mem_araddr_o  = pc;
  assign pc_o          = pc;
  assign inst_o        = inst;
  assign fault_o       = fault;
  assign fault_cause_o = cause;
  assign fetch_cnt_o   = fetch_cnt;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25060170_ifu
// Directed stimulus drives the memory and IDU sides; expected fetch addresses
// and {pc, inst} pairs are queued as each transaction is set up, and a
// monitor pops them whenever the DUT completes a handshake.
// ----------------------------------------------------------------------------
module tb_ysyx_25060170_ifu;

  logic        clk;
  logic        rst_n;
  logic        mem_arvalid_o;
  logic [31:0] mem_araddr_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  mem_rresp_i;
  logic        mem_rready_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        fault_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] fetch_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_ar_q[$];
  logic [63:0] exp_inst_q[$];

  ysyx_25060170_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_arvalid_o (mem_arvalid_o),
    .mem_araddr_o  (mem_araddr_o),
    .mem_arready_i (mem_arready_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_rresp_i   (mem_rresp_i),
    .mem_rready_o  (mem_rready_o),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes are predicted at the falling edge, with inputs stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_arvalid_o && mem_arready_i) begin
        if (exp_ar_q.size() == 0) begin
          chk("ar_unexpected", {32'h0, mem_araddr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("ar_addr", {32'h0, mem_araddr_o}, {32'h0, exp_ar_q.pop_front()});
        end
      end
      if (inst_valid_o && inst_ready_i) begin
        if (exp_inst_q.size() == 0) begin
          chk("inst_unexpected", {pc_o, inst_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("inst_out", {pc_o, inst_o}, exp_inst_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_arready_i = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
    mem_rresp_i   = 2'b00;
    inst_ready_i  = 1'b0;
    upd_valid_i   = 1'b0;
    upd_pc_i      = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_handshakes"}, {61'h0, mem_arvalid_o, mem_rready_o, inst_valid_o}, 64'h0);
    chk({tag, "_araddr"}, {32'h0, mem_araddr_o}, 64'h8000_0000);
    chk({tag, "_pc"}, {32'h0, pc_o}, 64'h8000_0000);
    chk({tag, "_inst"}, {32'h0, inst_o}, 64'h0);
    chk({tag, "_fault"}, {61'h0, fault_o, fault_cause_o}, 64'h0);
    chk({tag, "_cnt"}, {32'h0, fetch_cnt_o}, 64'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    apply_reset();
    chk_reset_outputs("rst");

    // Zero-wait first fetch
    mem_arready_i = 1'b1;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = 32'h0010_0093;
    inst_ready_i  = 1'b1;
    exp_ar_q.push_back(32'h8000_0000);
    exp_inst_q.push_back({32'h8000_0000, 32'h0010_0093});
    rst_n = 1'b1;
    step();
    chk("c1_arvalid", {63'h0, mem_arvalid_o}, 64'h1);
    step();
    chk("c2_rready", {63'h0, mem_rready_o}, 64'h1);
    step();
    chk("c3_inst_valid", {63'h0, inst_valid_o}, 64'h1);
    step();
    chk("cnt_after_first", {32'h0, fetch_cnt_o}, 64'h1);

    // Redirect to 0x8000_0010 with memory and IDU stalls
    idle_inputs();
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h8000_0010;
    exp_ar_q.push_back(32'h8000_0010);
    exp_inst_q.push_back({32'h8000_0010, 32'h0020_0113});
    step();
    upd_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("req_hold_arvalid", {63'h0, mem_arvalid_o}, 64'h1);
      chk("req_hold_araddr", {32'h0, mem_araddr_o}, 64'h8000_0010);
    end
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("wait_hold_rready", {63'h0, mem_rready_o}, 64'h1);
      chk("wait_hold_inst", {32'h0, inst_o}, 64'h0010_0093);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0020_0113;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hFFFF_FFFF;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h8000_0040;
    for (int i = 0; i < 4; i++) begin
      step();
      upd_valid_i = 1'b0;
      chk("out_hold_valid", {63'h0, inst_valid_o}, 64'h1);
      chk("out_hold_pc_inst", {pc_o, inst_o}, {32'h8000_0010, 32'h0020_0113});
      chk("out_hold_cnt", {32'h0, fetch_cnt_o}, 64'h1);
    end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    chk("cnt_once", {32'h0, fetch_cnt_o}, 64'h2);
    chk("pc_ignores_out_upd", {32'h0, pc_o}, 64'h8000_0010);

    // Misaligned next PC
    upd_valid_i   = 1'b1;
    upd_pc_i      = 32'h8000_0006;
    mem_arready_i = 1'b1;
    mem_rvalid_i  = 1'b1;
    step();
    upd_valid_i  = 1'b0;
    inst_ready_i = 1'b1;
    chk("mis_fault", {61'h0, fault_o, fault_cause_o}, {61'h0, 1'b1, 2'b10});
    chk("mis_pc", {32'h0, pc_o}, 64'h8000_0006);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mis_halted", {61'h0, mem_arvalid_o, mem_rready_o, inst_valid_o}, 64'h0);
    end
    chk("mis_cnt", {32'h0, fetch_cnt_o}, 64'h2);

    // Bus error response
    apply_reset();
    mem_arready_i = 1'b1;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = 32'h1234_5678;
    mem_rresp_i   = 2'b10;
    inst_ready_i  = 1'b1;
    exp_ar_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("bus_fault", {61'h0, fault_o, fault_cause_o}, {61'h0, 1'b1, 2'b01});
    chk("bus_inst_kept", {32'h0, inst_o}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bus_halted", {61'h0, mem_arvalid_o, mem_rready_o, inst_valid_o}, 64'h0);
    end

    // Reset in WAIT with a response arriving
    apply_reset();
    mem_arready_i = 1'b1;
    exp_ar_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    step();
    step();
    chk("pre_rst_wait", {63'h0, mem_rready_o}, 64'h1);
    mem_arready_i = 1'b0;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = 32'hDEAD_BEEF;
    rst_n         = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    step();
    chk("rst_inst_not_latched", {32'h0, inst_o}, 64'h0);
    mem_rvalid_i  = 1'b0;
    mem_arready_i = 1'b1;
    exp_ar_q.push_back(32'h8000_0000);
    exp_inst_q.push_back({32'h8000_0000, 32'h0030_0193});
    rst_n = 1'b1;
    step();
    chk("post_rst_req", {31'h0, mem_arvalid_o, mem_araddr_o}, {31'h0, 1'b1, 32'h8000_0000});
    chk("post_rst_inst", {32'h0, inst_o}, 64'h0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0030_0193;
    inst_ready_i = 1'b1;
    step();
    step();
    step();
    chk("post_rst_cnt", {32'h0, fetch_cnt_o}, 64'h1);

    step();
    chk("ar_queue_drained", {32'h0, 32'(exp_ar_q.size())}, 64'h0);
    chk("inst_queue_drained", {32'h0, 32'(exp_inst_q.size())}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_ifu.md
# ysyx_25060170_ifu

Instruction fetch unit for the multi-cycle ysyx_25060170 NPC core. It holds the architectural PC and fetches one 32-bit instruction per cycle-group from instruction memory over a valid/ready read channel. It presents `{pc, inst}` to the decode stage through a valid/ready handshake, then waits for the execute/writeback side to return the next PC before fetching again. It sits directly upstream of the IDU, which consumes `pc_o`/`inst_o`.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset; address of the first fetch.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_arvalid_o`  out  1  read-address request valid.
- `mem_araddr_o`  out  32  fetch address; equals the current PC.
- `mem_arready_i`  in  1  memory accepts the address.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  instruction word.
- `mem_rresp_i`  in  2  response code; 2'b00 = OK, anything else = bus error.
- `mem_rready_o`  out  1  IFU accepts read data.
- `inst_valid_o`  out  1  `pc_o`/`inst_o` valid toward the IDU.
- `inst_ready_i`  in  1  IDU accepts the instruction.
- `pc_o`  out  32  PC of the presented instruction.
- `inst_o`  out  32  presented instruction word.
- `upd_valid_i`  in  1  next-PC update from execute/writeback.
- `upd_pc_i`  in  32  next PC (PC+4, branch target, or jump target).
- `fault_o`  out  1  sticky fault flag; the IFU is halted while it is set.
- `fault_cause_o`  out  2  01 = bus error, 10 = misaligned next PC, 00 = none.
- `fetch_cnt_o`  out  32  count of instructions handed to the IDU; wraps modulo 2^32.

## Operation
- FSM states: IDLE, REQ, WAIT, OUT, EXEC, FAULT.
  - Reset: state = IDLE, pc = RESET_PC, inst = 0, count = 0, fault = 0, cause = 00.
- IDLE: always moves to REQ on the next cycle. This lets the first request start one cycle after reset is released.
- REQ: `mem_arvalid_o` = 1 and `mem_araddr_o` = pc. On `arvalid && arready`, go to WAIT.
- WAIT: `mem_rready_o` = 1. On `rvalid`:
  - If `rresp` = 00: latch `rdata` into inst and go to OUT.
  - Otherwise: latch the fault with cause 01 and go to FAULT. Do not update inst.
- OUT: `inst_valid_o` = 1. On `inst_ready_i`, increment the count and go to EXEC.
- EXEC: wait for `upd_valid_i`. When it arrives, pc <= `upd_pc_i`.
  - If `upd_pc_i[1:0]` == 0: go to REQ.
  - Otherwise: go to FAULT with cause 10. The bad target stays visible on `pc_o`.
- FAULT: terminal. All valid/ready outputs are 0. Only reset exits this state.
- `upd_valid_i` outside EXEC is ignored; pc is unchanged.
- `mem_rvalid_i` outside WAIT is ignored and never latched.
- Combinational outputs are decoded from the state register only: `mem_arvalid_o`, `mem_rready_o`, `inst_valid_o`. No input-to-output combinational path exists.
- `pc_o`, `mem_araddr_o`, `inst_o`, `fault_*` and `fetch_cnt_o` are driven directly from registers.

## Timing
- Reset values of outputs:
  - All valid/ready outputs 0.
  - `mem_araddr_o` = `pc_o` = RESET_PC.
  - `inst_o` = 0, `fault_o` = 0, `fault_cause_o` = 00, `fetch_cnt_o` = 0.
- Zero-wait memory (arready and rvalid both high in the same cycle they are first sampled):
  - `arvalid` high in cycle 1 after release.
  - WAIT in cycle 2.
  - `inst_valid_o` in cycle 3.
- Best-case loop from `upd_valid_i` to the next `inst_valid_o` is 3 cycles: REQ → WAIT → OUT.
- While REQ is held waiting, `mem_araddr_o` is stable. While OUT is held, `pc_o` and `inst_o` are stable. A stalled valid is never dropped.
- `fetch_cnt_o` updates in the cycle after the IDU handshake. 32'hFFFF_FFFF wraps to 0.
- Asserting reset in any state, including mid-WAIT with a response in flight, returns every register to its reset value immediately. The outstanding response must not be latched afterwards.

## Structure
- Shared package `ysyx_25060170_pkg` holds:
  - The FSM state enum.
  - The fault cause codes.
  - The RESP_OK constant.
  - RESET_PC default.
- The IDU and the other stages import the same package.
- Single module, no sub-module. The PC, inst, count and fault registers are simple enough that splitting them out adds only wiring.

## Test plan
- Reset, memory with arready=1 and rvalid=1 returning 32'h0010_0093 with OK response → `arvalid` cycle 1 at 32'h8000_0000; `inst_valid_o` cycle 3 with `pc_o` = 32'h8000_0000, `inst_o` = 32'h0010_0093.
- Memory adds 3 cycles of arready=0 and 2 cycles of rvalid=0; IDU holds `inst_ready_i` low for 4 cycles → `araddr` and `inst_o` are stable throughout; `fetch_cnt_o` increments exactly once.
- EXEC with `upd_pc_i` = 32'h8000_0010 → next request address is 32'h8000_0010. An `upd_valid_i` pulse during OUT → ignored, PC unchanged.
- `mem_rresp_i` = 2'b10 → `fault_o` = 1, `fault_cause_o` = 01, no further `arvalid`, `inst_valid_o` stays 0.
- `upd_pc_i` = 32'h8000_0006 → `fault_cause_o` = 10, `pc_o` = 32'h8000_0006, halted.
- `rst_n` low during WAIT, with `rvalid` arriving in the reset cycle → all outputs at reset values; the first request after release goes to RESET_PC with `inst_o` = 0.
